// File: rtl/i2c_single_reg_master.sv
// Single-master I2C controller: one-byte write or read against a single-register
// slave at DEV_ADDR. Drives open-drain SCL/SDA through o/t pairs (o == t, 1 = release).
// Command handshake: a command transfers on a cycle where cmd_valid && cmd_ready are
// both high; cmd_ready is high only in IDLE. rsp_valid is a one-cycle pulse with no
// backpressure, issued on the cycle the FSM re-enters IDLE.
module i2c_single_reg_master #(
  parameter logic [6:0] DEV_ADDR = 7'h70,
  parameter int         PRESCALE = 250
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_i,
  output logic       scl_o,
  output logic       scl_t,
  input  logic       sda_i,
  output logic       sda_o,
  output logic       sda_t,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_read,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_nack,
  output logic       busy,
  output logic [2:0] dbg_state
);

  localparam int QW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [QW-1:0] QMAX = QW'(PRESCALE - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_ADDR, S_ACK, S_WDATA, S_RDATA, S_STOP
  } state_t;

  state_t          r_state;
  state_t          r_ack_of;     // which byte the current ACK slot follows
  logic [QW-1:0]   r_qcnt;
  logic [1:0]      r_ph;
  logic [2:0]      r_bcnt;
  logic [7:0]      r_shift;
  logic [7:0]      r_wdata;
  logic [7:0]      r_rd;
  logic            r_read;
  logic            r_nack;
  logic            r_scl_o;
  logic            r_sda_o;
  logic            r_cmd_ready;
  logic            r_busy;
  logic            r_rsp_valid;
  logic            r_rsp_nack;
  logic [7:0]      r_rsp_rdata;
  logic            r_scl_s1, r_scl_s2;
  logic            r_sda_s1, r_sda_s2;

  logic            w_bit_state;
  logic            w_hold;
  logic            w_sample;

  assign w_bit_state = (r_state == S_ADDR) || (r_state == S_WDATA) ||
                       (r_state == S_RDATA) || (r_state == S_ACK);
  // The last count of a released-SCL quarter waits until the synced line is seen high.
  assign w_hold   = (r_qcnt == QMAX) && !r_scl_s2 &&
                    ((w_bit_state && (r_ph == 2'd2)) || ((r_state == S_STOP) && (r_ph == 2'd1)));
  assign w_sample = (r_qcnt == '0) && (r_ph == 2'd3);

  assign scl_o     = r_scl_o;
  assign scl_t     = r_scl_o;
  assign sda_o     = r_sda_o;
  assign sda_t     = r_sda_o;
  assign cmd_ready = r_cmd_ready;
  assign busy      = r_busy;
  assign rsp_valid = r_rsp_valid;
  assign rsp_nack  = r_rsp_nack;
  assign rsp_rdata = r_rsp_rdata;
  assign dbg_state = r_state;

  // Two-flop synchronizers for the pad inputs; idle bus reads high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scl_s1 <= 1'b1;
      r_scl_s2 <= 1'b1;
      r_sda_s1 <= 1'b1;
      r_sda_s2 <= 1'b1;
    end else begin
      r_scl_s1 <= scl_i;
      r_scl_s2 <= r_scl_s1;
      r_sda_s1 <= sda_i;
      r_sda_s2 <= r_sda_s1;
    end
  end

  // Transaction FSM: quarter-phase timing, bit shifting and registered line/response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_ack_of    <= S_ADDR;
      r_qcnt      <= '0;
      r_ph        <= 2'd0;
      r_bcnt      <= 3'd0;
      r_shift     <= 8'h00;
      r_wdata     <= 8'h00;
      r_rd        <= 8'h00;
      r_read      <= 1'b0;
      r_nack      <= 1'b0;
      r_scl_o     <= 1'b1;
      r_sda_o     <= 1'b1;
      r_cmd_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_nack  <= 1'b0;
      r_rsp_rdata <= 8'h00;
    end else begin
      r_rsp_valid <= 1'b0;
      if (r_state == S_IDLE) begin
        r_qcnt <= '0;
        r_ph   <= 2'd0;
        if (cmd_valid && r_cmd_ready) begin
          r_state     <= S_START;
          r_shift     <= {DEV_ADDR, cmd_read};
          r_wdata     <= cmd_wdata;
          r_read      <= cmd_read;
          r_nack      <= 1'b0;
          r_cmd_ready <= 1'b0;
          r_busy      <= 1'b1;
        end
      end else begin
        if (w_sample && (r_state == S_RDATA)) begin
          r_rd <= {r_rd[6:0], r_sda_s2};
        end
        if (w_sample && (r_state == S_ACK) && (r_ack_of != S_RDATA) && r_sda_s2) begin
          r_nack <= 1'b1;
        end
        if (w_hold) begin
          r_qcnt <= r_qcnt;
        end else if (r_qcnt != QMAX) begin
          r_qcnt <= r_qcnt + 1'b1;
        end else begin
          r_qcnt <= '0;
          r_ph   <= r_ph + 2'd1;
          case (r_state)
            S_START: begin
              if (r_ph == 2'd0) r_sda_o <= 1'b0;
              if (r_ph == 2'd2) begin
                r_state <= S_ADDR;
                r_ph    <= 2'd0;
                r_bcnt  <= 3'd7;
                r_scl_o <= 1'b0;
                r_sda_o <= r_shift[7];
              end
            end
            S_ADDR, S_WDATA, S_RDATA: begin
              if (r_ph == 2'd1) r_scl_o <= 1'b1;
              if (r_ph == 2'd3) begin
                r_scl_o <= 1'b0;
                if (r_bcnt == 3'd0) begin
                  r_state  <= S_ACK;
                  r_ack_of <= r_state;
                  r_sda_o  <= 1'b1;
                end else begin
                  r_bcnt  <= r_bcnt - 1'b1;
                  r_shift <= {r_shift[6:0], 1'b0};
                  r_sda_o <= (r_state == S_RDATA) ? 1'b1 : r_shift[6];
                end
              end
            end
            S_ACK: begin
              if (r_ph == 2'd1) r_scl_o <= 1'b1;
              if (r_ph == 2'd3) begin
                r_scl_o <= 1'b0;
                r_bcnt  <= 3'd7;
                if ((r_ack_of == S_ADDR) && !r_nack) begin
                  if (r_read) begin
                    r_state <= S_RDATA;
                    r_sda_o <= 1'b1;
                  end else begin
                    r_state <= S_WDATA;
                    r_shift <= r_wdata;
                    r_sda_o <= r_wdata[7];
                  end
                end else begin
                  r_state <= S_STOP;
                  r_sda_o <= 1'b0;
                end
              end
            end
            S_STOP: begin
              if (r_ph == 2'd0) r_scl_o <= 1'b1;
              if (r_ph == 2'd1) r_sda_o <= 1'b1;
              if (r_ph == 2'd2) begin
                r_state     <= S_IDLE;
                r_ph        <= 2'd0;
                r_rsp_valid <= 1'b1;
                r_rsp_nack  <= r_nack;
                if (r_read && !r_nack) r_rsp_rdata <= r_rd;
                r_busy      <= 1'b0;
                r_cmd_ready <= 1'b1;
              end
            end
            default: r_state <= S_IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_i2c_single_reg_master.sv
// Bench for i2c_single_reg_master with a behavioural single-register slave on a
// wired-AND bus, PRESCALE=4 (78*4 = 312 cycles per full transaction).
module tb_i2c_single_reg_master;

  logic       clk;
  logic       rst_n;
  logic       scl_o, scl_t, sda_o, sda_t;
  logic       scl_bus, sda_bus;
  logic       cmd_valid, cmd_ready, cmd_read;
  logic [7:0] cmd_wdata;
  logic       rsp_valid, rsp_nack, busy;
  logic [7:0] rsp_rdata;
  logic [2:0] dbg_state;

  logic       scl_hold = 1'b0;
  logic       s_drv    = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;
  int n_acc  = 0;
  int g_viol = 0;
  logic [8:0] exp_q[$];

  // slave model state
  logic [6:0] s_addr = 7'h70;
  logic [7:0] s_reg  = 8'h00;
  logic [7:0] s_sh   = 8'h00;
  logic       s_rw   = 1'b0;
  logic       s_mack = 1'b0;
  logic       p_scl  = 1'b1;
  logic       p_sda  = 1'b1;
  int         s_st   = 0;
  int         s_cnt  = 0;
  int         s_start_cnt = 0;
  int         s_stop_cnt  = 0;

  assign scl_bus = scl_o & ~scl_hold;
  assign sda_bus = sda_o & ~s_drv;

  i2c_single_reg_master #(.DEV_ADDR(7'h70), .PRESCALE(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl_i     (scl_bus),
    .scl_o     (scl_o),
    .scl_t     (scl_t),
    .sda_i     (sda_bus),
    .sda_o     (sda_o),
    .sda_t     (sda_t),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_read  (cmd_read),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_nack  (rsp_nack),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n && cmd_valid && cmd_ready) n_acc++;
  end

  // Behavioural slave: samples the bus each cycle, detects START/STOP and SCL edges.
  always @(negedge clk) begin
    if (p_scl && scl_bus && p_sda && !sda_bus) begin
      s_st = 1; s_cnt = 0; s_drv = 1'b0; s_start_cnt++;
    end else if (p_scl && scl_bus && !p_sda && sda_bus) begin
      s_st = 0; s_drv = 1'b0; s_stop_cnt++;
    end else if (!p_scl && scl_bus) begin
      case (s_st)
        1, 3: begin s_sh = {s_sh[6:0], sda_bus}; s_cnt++; end
        5: s_cnt++;
        6: begin s_mack = sda_bus; s_st = 0; end
        default: ;
      endcase
    end else if (p_scl && !scl_bus) begin
      case (s_st)
        1: if (s_cnt == 8) begin
             if (s_sh[7:1] == s_addr) begin s_drv = 1'b1; s_rw = s_sh[0]; s_st = 2; end
             else s_st = 7;
           end
        2: begin
             s_cnt = 0;
             if (s_rw) begin s_st = 5; s_drv = ~s_reg[7]; end
             else begin s_st = 3; s_drv = 1'b0; end
           end
        3: if (s_cnt == 8) begin s_reg = s_sh; s_drv = 1'b1; s_st = 4; end
        4: begin s_drv = 1'b0; s_st = 0; end
        5: if (s_cnt == 8) begin s_drv = 1'b0; s_st = 6; end
           else s_drv = ~s_reg[7 - s_cnt];
        default: ;
      endcase
    end
    p_scl = scl_bus;
    p_sda = sda_bus;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Driver: issue one command, optionally stretch SCL or pulse reset, measure latency.
  task automatic run_cmd(input logic rd, input logic [7:0] wd, input logic [7:0] exp_rd,
                         input logic exp_nack, input int st_at, input int st_len,
                         input int rst_at, output int lat);
    int guard;
    logic done;
    logic [8:0] e;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_read = rd; cmd_wdata = wd;
    if (rst_at < 0) exp_q.push_back({exp_nack, exp_rd});
    guard = 0;
    do begin @(posedge clk); guard++; end while (!cmd_ready && guard < 50);
    chk("accept_seen", (guard < 50), 1);
    lat = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (lat == 0) cmd_valid = 1'b0;
      if (st_len > 0 && lat == st_at) scl_hold = 1'b1;
      if (st_len > 0 && lat == st_at + st_len) scl_hold = 1'b0;
      if (lat == rst_at) begin
        rst_n = 1'b0;
        done = 1'b1;
      end else if (rsp_valid || lat > 3000) begin
        done = 1'b1;
      end else begin
        if (!busy || cmd_ready) g_viol++;
        @(posedge clk);
        lat++;
      end
    end
    if (rst_at < 0) begin
      chk("rsp_arrived", rsp_valid, 1);
      if (rsp_valid) begin
        e = exp_q.pop_front();
        chk("rsp_nack", rsp_nack, e[8]);
        if (rd) chk("rsp_rdata", rsp_rdata, e[7:0]);
      end
    end
  endtask

  initial begin
    int lat;
    int guard;
    int a0, st0, sp0;
    cmd_valid = 1'b0; cmd_read = 1'b0; cmd_wdata = 8'h00;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #20;
    chk("reset_outputs", {scl_o, scl_t, sda_o, sda_t, cmd_ready, busy, rsp_valid, rsp_nack, rsp_rdata},
        {1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
    chk("reset_state", dbg_state, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // 1: write A5
    g_viol = 0;
    run_cmd(1'b0, 8'hA5, 8'h00, 1'b0, -1, 0, -1, lat);
    chk("wr_latency", lat, 312);
    chk("wr_slave_reg", s_reg, 8'hA5);
    chk("wr_busy_drop", busy, 0);
    chk("wr_ready_back", cmd_ready, 1);
    chk("wr_busy_thru", g_viol, 0);

    // 2: read 3C, master NACKs the data byte
    repeat (5) @(negedge clk);
    s_reg = 8'h3C; s_mack = 1'b0;
    run_cmd(1'b1, 8'h00, 8'h3C, 1'b0, -1, 0, -1, lat);
    chk("rd_latency", lat, 312);
    chk("rd_master_nack", s_mack, 1);

    // 3: address NACK
    repeat (5) @(negedge clk);
    s_addr = 7'h71; st0 = s_start_cnt; sp0 = s_stop_cnt;
    run_cmd(1'b0, 8'h11, 8'h00, 1'b1, -1, 0, -1, lat);
    chk("nack_latency", lat, 168);
    chk("nack_reg_kept", s_reg, 8'h3C);
    chk("nack_rdata_kept", rsp_rdata, 8'h3C);
    repeat (5) @(negedge clk);
    chk("nack_starts", s_start_cnt - st0, 1);
    chk("nack_stops", s_stop_cnt - sp0, 1);
    s_addr = 7'h70;

    // 4: read with SCL held low 50 cycles during an address bit high phase
    s_reg = 8'hD2;
    run_cmd(1'b1, 8'h00, 8'hD2, 1'b0, 67, 50, -1, lat);
    chk("stretch_lat_window", ((lat >= 359) && (lat <= 365)), 1);
    if (lat < 359 || lat > 365) $display("stretch latency was %0d", lat);

    // 5: cmd_valid held high -> two back-to-back accepts
    repeat (5) @(negedge clk);
    a0 = n_acc; g_viol = 0;
    cmd_valid = 1'b1; cmd_read = 1'b0; cmd_wdata = 8'h5A;
    guard = 0;
    while (!busy && guard < 50) begin @(negedge clk); guard++; end
    cmd_wdata = 8'hC3;
    guard = 0;
    while (!rsp_valid && guard < 3000) begin
      if (!busy || cmd_ready) g_viol++;
      @(negedge clk); guard++;
    end
    chk("b2b_first_done", rsp_valid, 1);
    chk("b2b_first_reg", s_reg, 8'h5A);
    chk("b2b_first_ready", {busy, cmd_ready}, 2'b01);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 3000) begin
      if (!busy || cmd_ready) g_viol++;
      @(posedge clk); lat++;
      @(negedge clk);
    end
    chk("b2b_second_lat", lat, 312);
    chk("b2b_second_reg", s_reg, 8'hC3);
    chk("b2b_accepts", n_acc - a0, 2);
    chk("b2b_busy_thru", g_viol, 0);
    chk("b2b_rdata_kept", rsp_rdata, 8'hD2);
    chk("b2b_nack", rsp_nack, 0);

    // 6: reset during write data bit 4, then a clean write
    repeat (5) @(negedge clk);
    run_cmd(1'b0, 8'h99, 8'h00, 1'b0, -1, 0, 222, lat);
    #1;
    chk("midrst_outputs", {scl_o, scl_t, sda_o, sda_t, cmd_ready, busy, rsp_valid, rsp_nack, rsp_rdata},
        {1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
    chk("midrst_state", dbg_state, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    g_viol = 0;
    run_cmd(1'b0, 8'h77, 8'h00, 1'b0, -1, 0, -1, lat);
    chk("post_rst_latency", lat, 312);
    chk("post_rst_reg", s_reg, 8'h77);
    chk("post_rst_busy_thru", g_viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
